// File: rtl/speed_switch_requester_if.sv
// IO register bus signals driven by the speed-switch requester.
// The data byte is tri-stated, so it stays a plain inout on the requester.
interface speed_switch_requester_if;
    logic [15:0] O_IOREG_ADDR;
    logic        O_IOREG_WE_L;
    logic        O_IOREG_RE_L;

    modport master (output O_IOREG_ADDR, O_IOREG_WE_L, O_IOREG_RE_L);
    modport slave  (input  O_IOREG_ADDR, O_IOREG_WE_L, O_IOREG_RE_L);
endinterface

// File: rtl/speed_switch_requester.sv
// Writes KEY1, follows the clock block's disable window, reads KEY1 back and reports the speed mode.
// Optional: SPEED_SWITCH_VERIFY_EN flags a read-back that is not the inverse of the previous mode.
module speed_switch_requester #(
    parameter logic [15:0] P_KEY1_ADDR      = 16'hFF4D,
    parameter int unsigned P_STROBE_CYCLES  = 2,
    parameter logic [15:0] P_TIMEOUT_CYCLES = 16'd1023
) (
    input  logic                     I_CLK,
    input  logic                     I_SYNC_RESET_L,
    input  logic                     I_SWITCH_REQ,
    input  logic                     I_DISABLE_CONTROLLER,
    speed_switch_requester_if.master bus,
    inout  wire  [7:0]               IO_IOREG_DATA,
    output logic                     O_CPU_HALT,
    output logic                     O_SWITCH_BUSY,
    output logic                     O_SWITCH_DONE,
    output logic                     O_SWITCH_ERR,
    output logic                     O_IS_IN_DOUBLE_SPEEDMODE
);

    localparam logic [3:0] L_STROBE_LAST = 4'(P_STROBE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_SETUP,
        S_WR_STROBE,
        S_WR_RELEASE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RD_STROBE,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic        r_data_oe;
    logic        r_we_l;
    logic        r_re_l;
    logic        r_halt;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic        r_speed;
    logic [3:0]  r_strb;
    logic [15:0] r_tmo;

    logic        w_tmo_expired;
    logic        w_unused_rd_bits;

    assign w_tmo_expired    = (r_tmo <= 16'd1);
    // Only bit 7 of KEY1 carries the speed mode.
    assign w_unused_rd_bits = ^IO_IOREG_DATA[6:0];

    assign bus.O_IOREG_ADDR         = r_addr;
    assign bus.O_IOREG_WE_L         = r_we_l;
    assign bus.O_IOREG_RE_L         = r_re_l;
    assign IO_IOREG_DATA            = r_data_oe ? 8'h01 : 8'bz;
    assign O_CPU_HALT               = r_halt;
    assign O_SWITCH_BUSY            = r_busy;
    assign O_SWITCH_DONE            = r_done;
    assign O_SWITCH_ERR             = r_err;
    assign O_IS_IN_DOUBLE_SPEEDMODE = r_speed;

    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RESET_L) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_data_oe <= 1'b0;
            r_we_l    <= 1'b1;
            r_re_l    <= 1'b1;
            r_halt    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_speed   <= 1'b0;
            r_strb    <= '0;
            r_tmo     <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (I_SWITCH_REQ) begin
                        r_err     <= 1'b0;
                        r_halt    <= 1'b1;
                        r_busy    <= 1'b1;
                        r_addr    <= P_KEY1_ADDR;
                        r_data_oe <= 1'b1;
                        r_state   <= S_WR_SETUP;
                    end
                end
                S_WR_SETUP: begin
                    r_we_l  <= 1'b0;
                    r_strb  <= '0;
                    r_state <= S_WR_STROBE;
                end
                S_WR_STROBE: begin
                    if (r_strb == L_STROBE_LAST) begin
                        r_we_l  <= 1'b1;
                        r_strb  <= '0;
                        r_state <= S_WR_RELEASE;
                    end else begin
                        r_strb <= r_strb + 4'd1;
                    end
                end
                S_WR_RELEASE: begin
                    r_data_oe <= 1'b0;
                    r_addr    <= '0;
                    r_tmo     <= P_TIMEOUT_CYCLES;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (I_DISABLE_CONTROLLER) begin
                        r_tmo   <= P_TIMEOUT_CYCLES;
                        r_state <= S_WAIT_DONE;
                    end else if (w_tmo_expired) begin
                        r_tmo   <= '0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_halt  <= 1'b0;
                        r_state <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo - 16'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!I_DISABLE_CONTROLLER) begin
                        r_addr  <= P_KEY1_ADDR;
                        r_re_l  <= 1'b0;
                        r_strb  <= '0;
                        r_state <= S_RD_STROBE;
                    end else if (w_tmo_expired) begin
                        r_tmo   <= '0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_halt  <= 1'b0;
                        r_state <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo - 16'd1;
                    end
                end
                S_RD_STROBE: begin
                    if (r_strb == L_STROBE_LAST) begin
                        // Sampling at this edge captures the bus on the last low cycle.
                        r_speed <= IO_IOREG_DATA[7];
`ifdef SPEED_SWITCH_VERIFY_EN
                        r_err   <= (IO_IOREG_DATA[7] != ~r_speed);
`endif
                        r_re_l  <= 1'b1;
                        r_addr  <= '0;
                        r_strb  <= '0;
                        r_done  <= 1'b1;
                        r_halt  <= 1'b0;
                        r_state <= S_FINISH;
                    end else begin
                        r_strb <= r_strb + 4'd1;
                    end
                end
                S_FINISH, S_ERROR: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/speed_switch_requester.md
Name: speed_switch_requester

Overview:
- CPU-side initiator for the double-speed switch protocol on the IO register bus.
- On a speed-switch request from the CPU STOP decode, it writes 8'h01 to the KEY1 register address.
- It then tracks the clock block's controller-disable window and reads back the KEY1 status byte.
- It reports the new speed mode and any timeout to the CPU sequencer, and holds the CPU halted for the whole sequence.

Parameters:
- P_KEY1_ADDR, 16'hFF4D, IO register address of the KEY1 speed-switch register.
- P_STROBE_CYCLES, 2, number of cycles WE_L or RE_L is held low per access; legal range 1..15.
- P_TIMEOUT_CYCLES, 16'd1023, maximum cycles to wait for each edge of I_DISABLE_CONTROLLER.

Ports:
- I_CLK  input  1  system clock.
- I_SYNC_RESET_L  input  1  reset.
- I_SWITCH_REQ  input  1  one-cycle request pulse from CPU STOP decode.
- I_DISABLE_CONTROLLER  input  1  high while the clock block is performing the switch.
- O_IOREG_ADDR  output  16  IO bus address.
- IO_IOREG_DATA  inout  8  IO bus data, driven only while writing.
- O_IOREG_WE_L  output  1  IO write strobe, active low.
- O_IOREG_RE_L  output  1  IO read strobe, active low.
- O_CPU_HALT  output  1  holds the CPU while the sequence runs.
- O_SWITCH_BUSY  output  1  high in any state other than IDLE.
- O_SWITCH_DONE  output  1  one-cycle pulse when the sequence completes.
- O_SWITCH_ERR  output  1  sticky error flag; cleared by the next accepted request.
- O_IS_IN_DOUBLE_SPEEDMODE  output  1  speed mode as last confirmed.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset is sampled on the I_CLK rising edge while I_SYNC_RESET_L=0. Reset values:
  - state=IDLE
  - O_IOREG_ADDR=16'h0000
  - IO_IOREG_DATA=8'hZZ
  - WE_L=1, RE_L=1
  - O_CPU_HALT=0, O_SWITCH_BUSY=0, O_SWITCH_DONE=0, O_SWITCH_ERR=0
  - O_IS_IN_DOUBLE_SPEEDMODE=0
  - strobe and timeout counters = 0
- Reset asserted mid-sequence aborts the sequence: the bus is released immediately, with no partial strobe extension.
- State machine:
  - IDLE: on I_SWITCH_REQ=1, clear ERR, set HALT=1, and go to WR_SETUP. A request while not in IDLE is ignored; it is not queued.
  - WR_SETUP (1 cycle): ADDR=P_KEY1_ADDR, drive DATA=8'h01, WE_L=1.
  - WR_STROBE: WE_L=0 for exactly P_STROBE_CYCLES cycles; ADDR and DATA held stable.
  - WR_RELEASE (1 cycle): WE_L=1, DATA stays driven, ADDR held. Next cycle DATA goes to Z and ADDR to 16'h0000. Load the timeout counter with P_TIMEOUT_CYCLES.
  - WAIT_ACK: wait for I_DISABLE_CONTROLLER=1. The counter decrements each cycle; if it reaches 0 with the input still low, go to ERROR. On seeing the input high, reload the counter and go to WAIT_DONE.
  - WAIT_DONE: wait for I_DISABLE_CONTROLLER=0, with the same timeout rule.
  - RD_STROBE: ADDR=P_KEY1_ADDR, RE_L=0 for P_STROBE_CYCLES cycles. IO_IOREG_DATA is sampled on the last low cycle. RE_L returns to 1 the following cycle.
  - FINISH (1 cycle): O_IS_IN_DOUBLE_SPEEDMODE takes sampled bit 7. DONE=1 for this cycle, HALT=0, then IDLE.
  - ERROR (1 cycle): ERR=1, DONE=1, HALT=0, speed mode unchanged, then IDLE.
- If I_DISABLE_CONTROLLER is already high in the first WAIT_ACK cycle, it counts as the ack immediately.
- WE_L and RE_L are never low in the same cycle.
- Total latency with no wait, P_STROBE_CYCLES=2, and the ack/done edges each one cycle after entering the wait state = 11 cycles from request to DONE.
- Timeout counter is 16 bits and saturates at 0; it never wraps.

Optional Feature:
- Macro: SPEED_SWITCH_VERIFY_EN.
- With the macro defined, FINISH compares sampled bit 7 against the inverted previous O_IS_IN_DOUBLE_SPEEDMODE.
  - On mismatch: ERR=1, and the speed mode still updates to the sampled value.
  - DONE pulses in both cases.
- Without the macro, the read-back bit 7 is taken as-is and ERR is set only by timeout.

Test Plan:
- Reset then idle 20 cycles -> all strobes 1, DATA=Z, BUSY=0, speed=0.
- REQ pulse, model ack 3 cycles after WR_RELEASE, disable held 255 cycles, read returns 8'h80 -> write of 8'h01 to 16'hFF4D with WE_L low exactly 2 cycles, one read of FF4D, DONE pulse, speed=1, ERR=0, HALT high for the whole sequence.
- Repeat with read returning 8'h00 -> speed=0; with SPEED_SWITCH_VERIFY_EN defined and previous speed=1, ERR=0.
- Disable never asserted -> ERROR after 1023 wait cycles, ERR=1, DONE pulse, speed unchanged, bus idle.
- Second REQ pulse during WAIT_DONE -> ignored, exactly one write on the bus, one DONE.
- I_SYNC_RESET_L=0 during WR_STROBE -> next cycle WE_L=1, DATA=Z, HALT=0, state IDLE; a subsequent REQ runs normally.
